// File: rtl/ex_alu_sequencer_pkg.sv
// Shared op codes, widths and FSM state encodings for the EX-stage ALU sequencer.
// Optional feature macro: ALU_FAST_SHIFT_EN (barrel shifter instead of the iterative shift).
`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_XOR 4'd2
`define ALU_OR  4'd3
`define ALU_AND 4'd4
`define ALU_SLL 4'd5
`define ALU_SRL 4'd6
`define ALU_LT  4'd7
`define ALU_JAL 4'd8
`endif

package ex_alu_sequencer_pkg;
    localparam int ALU_CTL_W = `ALU_CONTROL_WIDTH;

    localparam logic [ALU_CTL_W-1:0] OP_ADD = `ALU_ADD;
    localparam logic [ALU_CTL_W-1:0] OP_SUB = `ALU_SUB;
    localparam logic [ALU_CTL_W-1:0] OP_XOR = `ALU_XOR;
    localparam logic [ALU_CTL_W-1:0] OP_OR  = `ALU_OR;
    localparam logic [ALU_CTL_W-1:0] OP_AND = `ALU_AND;
    localparam logic [ALU_CTL_W-1:0] OP_SLL = `ALU_SLL;
    localparam logic [ALU_CTL_W-1:0] OP_SRL = `ALU_SRL;
    localparam logic [ALU_CTL_W-1:0] OP_LT  = `ALU_LT;
    localparam logic [ALU_CTL_W-1:0] OP_JAL = `ALU_JAL;

    typedef enum logic {
        EXSEQ_IDLE  = 1'b0,
        EXSEQ_SHIFT = 1'b1
    } exseq_state_t;
endpackage

// File: rtl/ex_alu_sequencer_alu_core.sv
// Combinational single-cycle ALU (alu_core): result, zero and signed-less-than flag.
// Optional feature macro: ALU_FAST_SHIFT_EN adds full barrel shifts for SLL/SRL.
module alu_core
    import ex_alu_sequencer_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int CTL_W   = `ALU_CONTROL_WIDTH
) (
    input  logic [CTL_W-1:0] alu_ctl,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output logic             lt
);
    logic signed_lt;

    assign signed_lt = $signed(op_a) < $signed(op_b);

    always_comb begin
        result = '0;
        lt     = signed_lt;
        case (alu_ctl)
            OP_ADD: result = op_a + op_b;
            OP_SUB: result = op_a - op_b;
            OP_XOR: result = op_a ^ op_b;
            OP_OR:  result = op_a | op_b;
            OP_AND: result = op_a & op_b;
            OP_LT:  result = {{(XLEN-1){1'b0}}, signed_lt};
            OP_JAL: result = pc + XLEN'(4);
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL: result = op_a << op_b[SHAMT_W-1:0];
            OP_SRL: result = op_a >> op_b[SHAMT_W-1:0];
`else
            // Only the zero-shift case completes here; longer shifts go through the sequencer.
            OP_SLL, OP_SRL: result = (op_b[SHAMT_W-1:0] == '0) ? op_a : '0;
`endif
            default: lt = 1'b0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/ex_alu_sequencer.sv
// EX-stage ALU sequencer: valid/ready on both sides, iterative 1-bit SLL/SRL shifter.
// Optional feature macro: ALU_FAST_SHIFT_EN makes every op single-cycle and ties busy low.
module ex_alu_sequencer
    import ex_alu_sequencer_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int CTL_W   = `ALU_CONTROL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CTL_W-1:0] alu_ctl,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output logic             lt,
    output logic             busy
);
    logic [XLEN-1:0] core_result;
    logic            core_zero;
    logic            core_lt;
    logic [XLEN-1:0] result_reg, result_next;
    logic            zero_reg, zero_next;
    logic            lt_reg, lt_next;
    logic            out_valid_reg, out_valid_next;
    logic            hold;
    logic            accept;

    alu_core #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W),
        .CTL_W   (CTL_W)
    ) u_alu_core (
        .alu_ctl (alu_ctl),
        .op_a    (op_a),
        .op_b    (op_b),
        .pc      (pc),
        .result  (core_result),
        .zero    (core_zero),
        .lt      (core_lt)
    );

    assign hold = out_valid_reg && !out_ready;

`ifdef ALU_FAST_SHIFT_EN
    assign in_ready = !hold && !flush;
    assign busy     = 1'b0;
    assign accept   = in_valid && in_ready;

    always_comb begin
        result_next    = result_reg;
        zero_next      = zero_reg;
        lt_next        = lt_reg;
        out_valid_next = out_valid_reg;
        if (flush) begin
            out_valid_next = 1'b0;
        end else if (accept) begin
            result_next    = core_result;
            zero_next      = core_zero;
            lt_next        = core_lt;
            out_valid_next = 1'b1;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end
`else
    exseq_state_t     state_reg, state_next;
    logic [SHAMT_W-1:0] count_reg, count_next;
    logic [XLEN-1:0]  work_reg, work_next, work_shifted;
    logic             left_reg, left_next;
    logic             start_shift;

    assign in_ready    = (state_reg == EXSEQ_IDLE) && !hold && !flush;
    assign busy        = (state_reg == EXSEQ_SHIFT);
    assign accept      = in_valid && in_ready;
    assign start_shift = ((alu_ctl == OP_SLL) || (alu_ctl == OP_SRL)) && (op_b[SHAMT_W-1:0] != '0);
    assign work_shifted = left_reg ? {work_reg[XLEN-2:0], 1'b0} : {1'b0, work_reg[XLEN-1:1]};

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        work_next      = work_reg;
        left_next      = left_reg;
        result_next    = result_reg;
        zero_next      = zero_reg;
        lt_next        = lt_reg;
        out_valid_next = out_valid_reg;
        if (flush) begin
            state_next     = EXSEQ_IDLE;
            count_next     = '0;
            out_valid_next = 1'b0;
        end else if (state_reg == EXSEQ_SHIFT) begin
            work_next  = work_shifted;
            count_next = count_reg - 1'b1;
            if (count_reg == SHAMT_W'(1)) begin
                state_next     = EXSEQ_IDLE;
                result_next    = work_shifted;
                zero_next      = (work_shifted == '0);
                out_valid_next = 1'b1;
            end
        end else if (accept && start_shift) begin
            // lt reflects the operands as captured, even though the result arrives later.
            state_next     = EXSEQ_SHIFT;
            count_next     = op_b[SHAMT_W-1:0];
            work_next      = op_a;
            left_next      = (alu_ctl == OP_SLL);
            lt_next        = core_lt;
            out_valid_next = 1'b0;
        end else if (accept) begin
            result_next    = core_result;
            zero_next      = core_zero;
            lt_next        = core_lt;
            out_valid_next = 1'b1;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EXSEQ_IDLE;
            count_reg <= '0;
            work_reg  <= '0;
            left_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            work_reg  <= work_next;
            left_reg  <= left_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            lt_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            lt_reg        <= lt_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign result    = result_reg;
    assign zero      = zero_reg;
    assign lt        = lt_reg;
    assign out_valid = out_valid_reg;
endmodule

// File: tb/tb_ex_alu_sequencer.sv
// Self-checking bench for ex_alu_sequencer: directed scenarios plus randomized ops vs. a reference model.
// Honors ALU_FAST_SHIFT_EN when the bench is built with the same macro as the RTL.
`timescale 1ns/1ps
module tb_ex_alu_sequencer;
    import ex_alu_sequencer_pkg::*;

    localparam int XLEN  = 32;
    localparam int CTL_W = ALU_CTL_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CTL_W-1:0] alu_ctl = '0;
    logic [XLEN-1:0]  op_a = '0;
    logic [XLEN-1:0]  op_b = '0;
    logic [XLEN-1:0]  pc = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  result;
    logic             zero;
    logic             lt;
    logic             busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Expected outcome of one op; edges = clock edges after the accept edge until out_valid.
    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        lt;
        int          edges;
        int          acc;
    } exp_t;

    ex_alu_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .op_a      (op_a),
        .op_b      (op_b),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .lt        (lt),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [CTL_W-1:0] ctl, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] p);
        exp_t e;
        int   sh;
        sh      = int'(b[4:0]);
        e.lt    = ($signed(a) < $signed(b));
        e.edges = 0;
        e.acc   = 0;
        case (ctl)
            OP_ADD: e.res = a + b;
            OP_SUB: e.res = a - b;
            OP_XOR: e.res = a ^ b;
            OP_OR:  e.res = a | b;
            OP_AND: e.res = a & b;
            OP_SLL: begin e.res = a << sh; e.edges = sh; end
            OP_SRL: begin e.res = a >> sh; e.edges = sh; end
            OP_LT:  e.res = e.lt ? 32'd1 : 32'd0;
            OP_JAL: e.res = p + 32'd4;
            default: begin e.res = 32'd0; e.lt = 1'b0; end
        endcase
`ifdef ALU_FAST_SHIFT_EN
        e.edges = 0;
`endif
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Presents an op at a falling edge and returns just after the edge that accepts it.
    task automatic drive_accept(input logic [CTL_W-1:0] ctl, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] p);
        int n;
        n = 0;
        @(negedge clk);
        alu_ctl = ctl; op_a = a; op_b = b; pc = p; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        forever begin
            @(negedge clk);
            if (out_valid || edges >= 100) break;
            edges++;
        end
    endtask

    exp_t e;
    exp_t q[$];
    int   edges;
    logic [31:0] held;

    initial begin
        // Reset state while rst_n is still low
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_lt", 32'(lt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // ADD 5+7
        e = model(OP_ADD, 32'd5, 32'd7, 32'd0);
        drive_accept(OP_ADD, 32'd5, 32'd7, 32'd0);
        wait_valid(edges);
        check("add_latency", 32'(edges), 32'(e.edges));
        check("add_result", result, e.res);
        check("add_zero", 32'(zero), 32'(e.zero));

        // SLL 1 by 31: stalls for 31 cycles in iterative mode
        e = model(OP_SLL, 32'd1, 32'd31, 32'd0);
        drive_accept(OP_SLL, 32'd1, 32'd31, 32'd0);
        for (int k = 0; k < e.edges; k++) begin
            @(negedge clk);
            check("sll_busy", 32'(busy), 32'd1);
            check("sll_stall", 32'(in_ready), 32'd0);
            check("sll_no_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("sll_valid", 32'(out_valid), 32'd1);
        check("sll_result", result, 32'h8000_0000);
        check("sll_busy_done", 32'(busy), 32'd0);

        // BLT-style LT and SUB to zero
        drive_accept(OP_LT, 32'hFFFF_FFFB, 32'd1, 32'd0);
        wait_valid(edges);
        check("lt_result", result, 32'd1);
        check("lt_flag", 32'(lt), 32'd1);
        drive_accept(OP_SUB, 32'd9, 32'd9, 32'd0);
        wait_valid(edges);
        check("sub_zero", 32'(zero), 32'd1);
        check("sub_result", result, 32'd0);

        // Backpressure: ADD held for 3 cycles, queued XOR accepted on release
        drive_accept(OP_ADD, 32'd100, 32'd23, 32'd0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                alu_ctl = OP_XOR; op_a = 32'hFF00_FF00; op_b = 32'h0FF0_0FF0; in_valid = 1'b1;
            end
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result_held", result, 32'd123);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        held = result;
        check("bp_result_before", held, 32'd123);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        e = model(OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0);
        check("bp_xor_valid", 32'(out_valid), 32'd1);
        check("bp_xor_result", result, e.res);

        // Flush on the 4th cycle of SRL
        drive_accept(OP_SRL, 32'hF000_0000, 32'd10, 32'd0);
        repeat (3) @(negedge clk);
        flush = 1'b1; alu_ctl = OP_ADD; op_a = 32'd1; op_b = 32'd2; in_valid = 1'b1;
        #1;
        check("flush_blocks_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);

        // SRL with shamt 0 takes the single-cycle path
        drive_accept(OP_SRL, 32'hF000_0000, 32'd0, 32'd0);
        wait_valid(edges);
        check("srl0_latency", 32'(edges), 32'd0);
        check("srl0_result", result, 32'hF000_0000);

        // JAL and an undefined op code
        drive_accept(OP_JAL, 32'd0, 32'd0, 32'h0000_1000);
        wait_valid(edges);
        check("jal_result", result, 32'h0000_1004);
        drive_accept(CTL_W'(4'd13), 32'd3, 32'd7, 32'd0);
        wait_valid(edges);
        check("undef_result", result, 32'd0);
        check("undef_zero", 32'(zero), 32'd1);
        check("undef_lt", 32'(lt), 32'd0);

        // Asynchronous reset in the middle of a shift
        drive_accept(OP_SLL, 32'd1, 32'd20, 32'd0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_accept(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0);
        wait_valid(edges);
        check("arst_add_latency", 32'(edges), 32'd0);
        check("arst_add_result", result, 32'h8000_0000);

        // Randomized ops with random backpressure, scored in order
        begin
            int  sent;
            bit  pending;
            bit  seen;
            exp_t r;
            sent = 0; pending = 0; seen = 0;
            for (int t = 0; t < 6000 && (sent < 150 || q.size() > 0); t++) begin
                @(negedge clk);
                if (!pending && sent < 150 && $urandom_range(0, 3) != 0) begin
                    alu_ctl = CTL_W'($urandom_range(0, 10));
                    op_a = $urandom();
                    op_b = ($urandom_range(0, 7) == 0) ? op_a : $urandom();
                    pc = $urandom();
                    in_valid = 1'b1;
                    pending = 1;
                end
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("rnd_spurious_valid", 32'(out_valid), 32'd0);
                    end else begin
                        if (!seen) begin
                            check("rnd_latency", 32'(cyc - q[0].acc), 32'(q[0].edges));
                            seen = 1;
                        end
                        if (out_ready) begin
                            check("rnd_result", result, q[0].res);
                            check("rnd_zero", 32'(zero), 32'(q[0].zero));
                            check("rnd_lt", 32'(lt), 32'(q[0].lt));
                            void'(q.pop_front());
                            seen = 0;
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    r = model(alu_ctl, op_a, op_b, pc);
                    r.acc = cyc + 1;
                    q.push_back(r);
                    pending = 0;
                    sent++;
                end
                @(posedge clk);
                #1;
                if (!pending) in_valid = 1'b0;
            end
            check("rnd_all_sent", 32'(sent), 32'd150);
            check("rnd_drained", 32'(q.size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
